if_stage: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline. It owns the program counter and drives a req/ack instruction-memory port. It also owns the IF/ID pipeline register that supplies `pc`/`inst` to the decode stage. It applies decode-stage stalls and branch/jump redirects (`branch_flag`/`branch_addr`), and holds a one-entry skid buffer so a fetch completing during a stall is never lost.

---
 rtl/if_stage_if.sv | 10 +
 rtl/if_stage.sv | 180 ++++++++++++++++++
 tb/tb_if_stage.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Instruction-memory request/acknowledge bus: the fetch stage is the master, memory the slave.
interface if_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC, imem req/ack port, IF/ID register and a one-entry skid buffer.
// Define IF_DELAY_SLOT_EN to execute the branch delay slot; undefined squashes it instead.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_flag,
  input  logic [31:0] branch_addr,
  if_stage_if.master  imem,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        if_valid,
  output logic        fetch_busy
);
  typedef enum logic {FETCH, HOLD} state_t;

  state_t      state, state_nx;
  logic [31:0] fetch_pc, fetch_pc_nx;
  logic [31:0] sk_pc, sk_pc_nx;
  logic [31:0] sk_inst, sk_inst_nx;
  logic [31:0] pc_nx, inst_nx;
  logic        if_valid_nx;
`ifdef IF_DELAY_SLOT_EN
  logic        redir_pend, redir_pend_nx;
  logic [31:0] redir_pc, redir_pc_nx;
`else
  logic        drop_pend, drop_pend_nx;
  logic [31:0] drop_pc, drop_pc_nx;
`endif
  logic [31:0] target;
  logic        take;
  logic        ack;
  logic        unused_addr_bits;

  assign target           = {branch_addr[31:2], 2'b00};
  assign unused_addr_bits = ^branch_addr[1:0];
  assign take             = branch_flag & ~stall & if_valid;
  assign imem.req         = rst & (state == FETCH);
  assign imem.addr        = fetch_pc;
  assign ack              = imem.req & imem.ack;
  assign fetch_busy       = imem.req & ~imem.ack;

  always_comb begin
    // NOTE: every signal written here gets its default first, so no path can infer a latch.
    state_nx    = state;
    fetch_pc_nx = fetch_pc;
    sk_pc_nx    = sk_pc;
    sk_inst_nx  = sk_inst;
    pc_nx       = pc;
    inst_nx     = inst;
    if_valid_nx = if_valid;
`ifdef IF_DELAY_SLOT_EN
    redir_pend_nx = redir_pend;
    redir_pc_nx   = redir_pc;
`else
    drop_pend_nx  = drop_pend;
    drop_pc_nx    = drop_pc;
`endif

    case (state)
      FETCH: begin
`ifdef IF_DELAY_SLOT_EN
        // The fetch in flight at acceptance is the delay slot and always completes normally.
        if (ack) begin
          if (stall) begin
            sk_pc_nx   = fetch_pc;
            sk_inst_nx = imem.rdata;
            state_nx   = HOLD;
          end else begin
            pc_nx       = fetch_pc;
            inst_nx     = imem.rdata;
            if_valid_nx = 1'b1;
          end
          if (take) begin
            fetch_pc_nx = target;
          end else if (redir_pend) begin
            fetch_pc_nx   = redir_pc;
            redir_pend_nx = 1'b0;
          end else begin
            fetch_pc_nx = fetch_pc + 32'd4;
          end
        end else begin
          if (!stall) begin
            inst_nx     = NOP_INST;
            if_valid_nx = 1'b0;
          end
          if (take) begin
            redir_pend_nx = 1'b1;
            redir_pc_nx   = target;
          end
        end
`else
        // A squashed fetch keeps its address on the bus until acked, then its data is thrown away.
        if (drop_pend || take) begin
          if (!stall) begin
            inst_nx     = NOP_INST;
            if_valid_nx = 1'b0;
          end
          if (ack) begin
            fetch_pc_nx  = drop_pend ? drop_pc : target;
            drop_pend_nx = 1'b0;
          end else if (take) begin
            drop_pend_nx = 1'b1;
            drop_pc_nx   = target;
          end
        end else if (ack) begin
          if (stall) begin
            sk_pc_nx   = fetch_pc;
            sk_inst_nx = imem.rdata;
            state_nx   = HOLD;
          end else begin
            pc_nx       = fetch_pc;
            inst_nx     = imem.rdata;
            if_valid_nx = 1'b1;
          end
          fetch_pc_nx = fetch_pc + 32'd4;
        end else if (!stall) begin
          inst_nx     = NOP_INST;
          if_valid_nx = 1'b0;
        end
`endif
      end
      HOLD: begin
        if (!stall) begin
          state_nx    = FETCH;
          pc_nx       = sk_pc;
          inst_nx     = sk_inst;
          if_valid_nx = 1'b1;
          if (take) begin
            fetch_pc_nx = target;
`ifndef IF_DELAY_SLOT_EN
            pc_nx       = pc;
            inst_nx     = NOP_INST;
            if_valid_nx = 1'b0;
`endif
          end
        end
      end
      default: state_nx = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (!rst) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
      sk_pc    <= '0;
      sk_inst  <= NOP_INST;
      pc       <= '0;
      inst     <= NOP_INST;
      if_valid <= 1'b0;
`ifdef IF_DELAY_SLOT_EN
      redir_pend <= 1'b0;
      redir_pc   <= '0;
`else
      drop_pend  <= 1'b0;
      drop_pc    <= '0;
`endif
    end else begin
      state    <= state_nx;
      fetch_pc <= fetch_pc_nx;
      sk_pc    <= sk_pc_nx;
      sk_inst  <= sk_inst_nx;
      pc       <= pc_nx;
      inst     <= inst_nx;
      if_valid <= if_valid_nx;
`ifdef IF_DELAY_SLOT_EN
      redir_pend <= redir_pend_nx;
      redir_pc   <= redir_pc_nx;
`else
      drop_pend  <= drop_pend_nx;
      drop_pc    <= drop_pc_nx;
`endif
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage: memory model with variable latency, program-flow reference
// model feeding a scoreboard of expected {pc, inst}, and a monitor on the IF/ID register.
module tb_if_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_flag;
  logic [31:0] branch_addr;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        if_valid;
  logic        fetch_busy;

  if_stage_if imem_bus ();

  if_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .branch_flag(branch_flag),
    .branch_addr(branch_addr),
    .imem       (imem_bus),
    .pc         (pc),
    .inst       (inst),
    .if_valid   (if_valid),
    .fetch_busy (fetch_busy)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Stimulus knobs shared by the driver, memory and monitor processes.
  int          fixed_lat   = 0;   // -1 selects a random latency per request
  int          stall_pct   = 0;
  int          branch_pct  = 0;
  bit          hold_chk_en = 1'b0;
  bit          run_chk     = 1'b1;
  bit          acc_flag    = 1'b0;
  logic [31:0] acc_tgt     = '0;
  logic [31:0] seq_pc      = RESET_PC;
  fetch_t      exp_q[$];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
  endfunction

  // Reference model: the instruction stream decode should see, in program order.
  task automatic step(input logic rst_v);
    logic        acc;
    logic [31:0] tgt;
`ifdef IF_DELAY_SLOT_EN
    fetch_t      head;
`endif
    @(negedge clk);
    #1;
    rst         = rst_v;
    stall       = rst_v && ($urandom_range(99) < stall_pct);
    branch_flag = ($urandom_range(99) < branch_pct);
    branch_addr = $urandom_range(0, 1023);
    if (!rst_v) begin
      exp_q.delete();
      seq_pc = RESET_PC;
    end else begin
      acc = branch_flag && !stall && if_valid;
      if (acc) begin
        tgt = {branch_addr[31:2], 2'b00};
`ifdef IF_DELAY_SLOT_EN
        head = exp_q[0];
        exp_q.delete();
        exp_q.push_back(head);
`else
        exp_q.delete();
`endif
        seq_pc   = tgt;
        acc_flag = 1'b1;
        acc_tgt  = tgt;
      end
      while (exp_q.size() < 4) begin
        exp_q.push_back(fetch_t'{pc: seq_pc, inst: mem_word(seq_pc)});
        seq_pc = seq_pc + 32'd4;
      end
    end
  endtask

  // Memory: random/fixed latency, checks address stability, HOLD idling and redirect targets.
  initial begin : memory
    int          remain;
    logic        outstanding, hold_exp, waiting, armed;
    logic [31:0] req_addr, wait_tgt, armed_tgt;
    remain = 0; outstanding = 1'b0; hold_exp = 1'b0; waiting = 1'b0; armed = 1'b0;
    req_addr = '0; wait_tgt = '0; armed_tgt = RESET_PC;
    imem_bus.ack   = 1'b0;
    imem_bus.rdata = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        imem_bus.ack   = 1'($urandom_range(1));
        imem_bus.rdata = $urandom;
        outstanding = 1'b0; hold_exp = 1'b0; waiting = 1'b0;
        armed = 1'b1; armed_tgt = RESET_PC; acc_flag = 1'b0;
      end else begin
        if (armed && imem_bus.req) begin
          check("target_addr", imem_bus.addr, armed_tgt);
          armed = 1'b0;
        end
        if (hold_chk_en && hold_exp) check("hold_req", imem_bus.req, 32'd0);
        if (imem_bus.req) begin
          if (!outstanding) begin
            outstanding = 1'b1;
            req_addr    = imem_bus.addr;
            remain      = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
          end else begin
            check("addr_stable", imem_bus.addr, req_addr);
          end
          if (remain == 0) begin
            imem_bus.ack   = 1'b1;
            imem_bus.rdata = mem_word(imem_bus.addr);
            outstanding    = 1'b0;
          end else begin
            imem_bus.ack   = 1'b0;
            imem_bus.rdata = $urandom;
            remain--;
          end
        end else begin
          imem_bus.ack   = 1'b0;
          imem_bus.rdata = $urandom;
        end
        hold_exp = stall && (hold_exp || imem_bus.ack);
        if (acc_flag) begin
          waiting  = 1'b1;
          wait_tgt = acc_tgt;
          acc_flag = 1'b0;
        end
        if (waiting && (imem_bus.ack || !imem_bus.req)) begin
          armed     = 1'b1;
          armed_tgt = wait_tgt;
          waiting   = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever IF/ID loads a real instruction.
  initial begin : monitor
    fetch_t want, shown;
    logic   shown_valid;
    int     run;
    want = '0; shown = fetch_t'{pc: 32'd0, inst: NOP_INST}; shown_valid = 1'b0; run = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("rst_if_valid", if_valid, 32'd0);
        check("rst_pc", pc, 32'd0);
        check("rst_inst", inst, NOP_INST);
        check("rst_req", imem_bus.req, 32'd0);
        check("rst_addr", imem_bus.addr, RESET_PC);
        shown = fetch_t'{pc: 32'd0, inst: NOP_INST};
        shown_valid = 1'b0;
        run = 0;
      end else if (!stall) begin
        if (if_valid) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_empty: got pc %h, expected no instruction", pc);
          end else begin
            want = exp_q.pop_front();
            check("pc", pc, want.pc);
            check("inst", inst, want.inst);
            if (run_chk) check("bubble_run", run, fixed_lat);
            shown = want;
          end
          shown_valid = 1'b1;
          run = 0;
        end else begin
          check("bubble_inst", inst, NOP_INST);
          check("bubble_pc", pc, shown.pc);
          shown.inst  = NOP_INST;
          shown_valid = 1'b0;
          run++;
        end
      end else begin
        check("stall_valid", if_valid, shown_valid);
        check("stall_pc", pc, shown.pc);
        check("stall_inst", inst, shown.inst);
      end
      check("fetch_busy", fetch_busy, imem_bus.req & ~imem_bus.ack);
    end
  end

  initial begin : main
    rst = 1'b0; stall = 1'b0; branch_flag = 1'b0; branch_addr = '0;

    // Zero-latency memory: one instruction per cycle.
    fixed_lat = 0; run_chk = 1'b1;
    repeat (3) step(1'b0);
    repeat (20) step(1'b1);

    // Two-cycle latency: exactly two bubbles before every instruction.
    fixed_lat = 2;
    repeat (2) step(1'b0);
    repeat (24) step(1'b1);

    // Random latency with random stalls: skid buffer and HOLD behaviour.
    fixed_lat = -1; stall_pct = 30; hold_chk_en = 1'b1; run_chk = 1'b0;
    repeat (2) step(1'b0);
    repeat (80) step(1'b1);

    // Reset in the middle of a slow fetch; acks during reset must be ignored.
    fixed_lat = 3; stall_pct = 0;
    repeat (2) step(1'b0);
    repeat (2) step(1'b1);
    repeat (2) step(1'b0);
    repeat (12) step(1'b1);

    // Random latency, stalls and branches, including branch requests under stall.
    fixed_lat = -1; stall_pct = 25; branch_pct = 20; hold_chk_en = 1'b0;
    repeat (2) step(1'b0);
    repeat (400) step(1'b1);

    branch_pct = 0; stall_pct = 0;
    repeat (4) step(1'b1);
    @(negedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
